// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (read-only) and the MEM stage (load/store). One transaction is in flight at a
// time. Data requests win arbitration unless fetch has been starved for
// STARVE_LIMIT consecutive data grants. A branch flush drops the response of an
// in-flight fetch.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   if_*                    fetch port: req/addr/flush in, gnt/rvalid/rdata out
//   dm_*                    data port: req/we/be/addr/wdata in, gnt/rvalid/rdata out
//   mem_*                   memory side: registered request fields out,
//                           gnt/rvalid/rdata in
//   busy_o                  a transaction is in flight (state != idle)
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_flush_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e                state_q, state_d;
  logic                  owner_if_q, owner_if_d;
  logic                  drop_q, drop_d;
  logic [CntW-1:0]       starve_q, starve_d;
  logic                  mem_we_q, mem_we_d;
  logic [BeW-1:0]        mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  dm_rvalid_q, dm_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  fetch_ok;
  logic                  grant_if, grant_dm;

  // Arbitration. A flush in idle makes the fetch request invisible this cycle,
  // so a starved fetch that is being flushed does not block the data port.
  always_comb begin
    fetch_ok = if_req_i & ~if_flush_i;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == StIdle && !rst_i) begin
      if (dm_req_i && !(fetch_ok && starve_q == StarveMax)) begin
        grant_dm = 1'b1;
      end else if (fetch_ok) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (grant_if) begin
          state_d     = StReq;
          owner_if_d  = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = {BeW{1'b1}};
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          starve_d    = '0;
        end else if (grant_dm) begin
          state_d     = StReq;
          owner_if_d  = 1'b0;
          mem_we_d    = dm_we_i;
          mem_be_d    = dm_be_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (!if_req_i) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + CntW'(1);
          end
        end else if (!if_req_i) begin
          starve_d = '0;
        end
      end
      StReq: begin
        if (owner_if_q && if_flush_i) drop_d = 1'b1;
        if (mem_gnt_i) state_d = StRsp;
      end
      StRsp: begin
        if (mem_rvalid_i) begin
          state_d = StIdle;
          drop_d  = 1'b0;
          if (!owner_if_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata_i;
          end else if (!(drop_q || if_flush_i)) begin
            // A flush arriving together with the response also discards it.
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end else if (owner_if_q && if_flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_if_q  <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = grant_if;
  assign dm_gnt_o    = grant_dm;
  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions,
// hand-written multi-cycle sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
  logic [BW-1:0] dm_be_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i, dm_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_be_i     (dm_be_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  typedef struct {
    bit            fetch;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            gnt_wait;
    int            rsp_wait;
    logic          exp_we;
    logic [BW-1:0] exp_be;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_if_rd, exp_dm_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " if_gnt"}, if_gnt_o, 0);
    chk({tag, " dm_gnt"}, dm_gnt_o, 0);
    chk({tag, " if_rvalid"}, if_rvalid_o, 0);
    chk({tag, " dm_rvalid"}, dm_rvalid_o, 0);
    chk({tag, " mem_req"}, mem_req_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " mem_we"}, mem_we_o, 0);
    chk({tag, " mem_be"}, mem_be_o, 0);
    chk({tag, " mem_addr"}, mem_addr_o, 0);
    chk({tag, " mem_wdata"}, mem_wdata_o, 0);
    chk({tag, " if_rdata"}, if_rdata_o, 0);
    chk({tag, " dm_rdata"}, dm_rdata_o, 0);
  endtask

  // One complete transaction from an idle arbiter with the given memory delays.
  task automatic run_txn(input vec_t v, input string tag);
    cyc();
    mem_gnt_i = 0; mem_rvalid_i = 0;
    if (v.fetch) begin
      if_req_i = 1; if_addr_i = v.addr;
    end else begin
      dm_req_i = 1; dm_we_i = v.we; dm_be_i = v.be; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
    end
    @(negedge clk);
    chk({tag, " if_gnt"}, if_gnt_o, v.fetch);
    chk({tag, " dm_gnt"}, dm_gnt_o, !v.fetch);
    chk({tag, " busy@gnt"}, busy_o, 0);
    chk({tag, " mem_req@gnt"}, mem_req_o, 0);
    cyc();
    if_req_i = 0; dm_req_i = 0;
    for (int w = 0; w <= v.gnt_wait; w++) begin
      if (w == v.gnt_wait) mem_gnt_i = 1;
      @(negedge clk);
      chk({tag, " mem_req"}, mem_req_o, 1);
      chk({tag, " mem_addr"}, mem_addr_o, v.addr);
      chk({tag, " mem_we"}, mem_we_o, v.exp_we);
      chk({tag, " mem_be"}, mem_be_o, v.exp_be);
      if (!v.fetch) chk({tag, " mem_wdata"}, mem_wdata_o, v.wdata);
      chk({tag, " rvalid@req"}, {if_rvalid_o, dm_rvalid_o}, 0);
      chk({tag, " gnt@req"}, {if_gnt_o, dm_gnt_o}, 0);
      cyc();
    end
    mem_gnt_i = 0;
    for (int w = 0; w <= v.rsp_wait; w++) begin
      if (w == v.rsp_wait) begin
        mem_rvalid_i = 1; mem_rdata_i = v.rdata;
      end
      @(negedge clk);
      chk({tag, " mem_req@rsp"}, mem_req_o, 0);
      chk({tag, " busy@rsp"}, busy_o, 1);
      chk({tag, " rvalid@rsp"}, {if_rvalid_o, dm_rvalid_o}, 0);
      cyc();
    end
    mem_rvalid_i = 0;
    if (v.fetch) exp_if_rd = v.rdata;
    else exp_dm_rd = v.rdata;
    @(negedge clk);
    chk({tag, " if_rvalid"}, if_rvalid_o, v.fetch);
    chk({tag, " dm_rvalid"}, dm_rvalid_o, !v.fetch);
    chk({tag, " if_rdata"}, if_rdata_o, exp_if_rd);
    chk({tag, " dm_rdata"}, dm_rdata_o, exp_dm_rd);
    chk({tag, " busy@done"}, busy_o, 0);
  endtask

  // Reference model state for the random phase (transaction level).
  bit            m_act, m_acc, m_own_if, m_drop, clr_if, clr_dm;
  bit            g_if, g_dm, f_ok, e_if_rv, e_dm_rv;
  int unsigned   m_starve;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    tbl[0] = '{1, 32'h100, 0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0, 0, 4'hF};
    tbl[1] = '{0, 32'h200, 1, 4'b0011, 32'h1234, 32'h0, 0, 0, 1, 4'b0011};
    tbl[2] = '{0, 32'h300, 0, 4'hF, 32'h0, 32'hCAFEF00D, 1, 2, 0, 4'hF};
    tbl[3] = '{1, 32'h104, 0, 4'h0, 32'h0, 32'h01234567, 5, 0, 0, 4'hF};
    tbl[4] = '{0, 32'h3FC, 1, 4'b1000, 32'hA5A55A5A, 32'h0, 5, 3, 1, 4'b1000};
    tbl[5] = '{1, 32'h108, 0, 4'h0, 32'h0, 32'h89ABCDEF, 2, 1, 0, 4'hF};

    clear_inputs();
    rst = 1;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    cyc();
    rst = 0;
    @(negedge clk);
    chk("post-reset busy", busy_o, 0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Simultaneous requests: data first, fetch at the next idle.
    cyc();
    if_req_i = 1; if_addr_i = 32'h110;
    dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h200; dm_wdata_i = 32'h1234;
    @(negedge clk);
    chk("simul dm_gnt", dm_gnt_o, 1);
    chk("simul if_gnt", if_gnt_o, 0);
    cyc();
    dm_req_i = 0; mem_gnt_i = 1;
    @(negedge clk);
    chk("simul mem_we", mem_we_o, 1);
    chk("simul mem_be", mem_be_o, 4'b0011);
    chk("simul mem_addr", mem_addr_o, 32'h200);
    chk("simul mem_wdata", mem_wdata_o, 32'h1234);
    chk("simul if_gnt busy", if_gnt_o, 0);
    cyc();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D;
    cyc();
    mem_rvalid_i = 0;
    exp_dm_rd = 32'h0BADF00D;
    @(negedge clk);
    chk("simul dm_rvalid", dm_rvalid_o, 1);
    chk("simul dm_rdata", dm_rdata_o, exp_dm_rd);
    chk("simul if_gnt 2nd", if_gnt_o, 1);
    cyc();
    if_req_i = 0; mem_gnt_i = 1;
    @(negedge clk);
    chk("simul f mem_addr", mem_addr_o, 32'h110);
    chk("simul f mem_we", mem_we_o, 0);
    chk("simul f mem_be", mem_be_o, 4'hF);
    cyc();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11110000;
    cyc();
    mem_rvalid_i = 0;
    exp_if_rd = 32'h11110000;
    @(negedge clk);
    chk("simul if_rvalid", if_rvalid_o, 1);
    chk("simul if_rdata", if_rdata_o, exp_if_rd);

    // Starvation: SL data grants, then fetch, then data again.
    dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h500;
    for (int k = 0; k < 6; k++) begin
      cyc();
      mem_rvalid_i = 0; if_req_i = 1; dm_req_i = 1;
      @(negedge clk);
      chk($sformatf("starve%0d if_gnt", k), if_gnt_o, (k == SL));
      chk($sformatf("starve%0d dm_gnt", k), dm_gnt_o, (k != SL));
      if (k > 0) begin
        chk($sformatf("starve%0d prev rvalid", k), {if_rvalid_o, dm_rvalid_o},
            (k - 1 == SL) ? 2'b10 : 2'b01);
      end
      cyc();
      mem_gnt_i = 1;
      cyc();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h50000000 + k;
      if (k == SL) exp_if_rd = 32'h50000000 + k;
      else exp_dm_rd = 32'h50000000 + k;
    end
    cyc();
    mem_rvalid_i = 0; if_req_i = 0; dm_req_i = 0;
    @(negedge clk);
    chk("starve last dm_rvalid", dm_rvalid_o, 1);
    chk("starve if_rdata", if_rdata_o, exp_if_rd);
    chk("starve dm_rdata", dm_rdata_o, exp_dm_rd);

    // Flush in idle blocks fetch; data may still win.
    cyc();
    if_req_i = 1; if_flush_i = 1; if_addr_i = 32'h600;
    @(negedge clk);
    chk("idleflush if_gnt", if_gnt_o, 0);
    cyc();
    dm_req_i = 1; dm_addr_i = 32'h700;
    @(negedge clk);
    chk("idleflush dm_gnt", dm_gnt_o, 1);
    chk("idleflush if_gnt2", if_gnt_o, 0);
    cyc();
    dm_req_i = 0; if_req_i = 0; if_flush_i = 0; mem_gnt_i = 1;
    cyc();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77777777;
    cyc();
    mem_rvalid_i = 0;
    exp_dm_rd = 32'h77777777;
    @(negedge clk);
    chk("idleflush dm_rdata", dm_rdata_o, exp_dm_rd);

    // Flush during the response phase drops the fetch response.
    cyc();
    if_req_i = 1; if_addr_i = 32'h400;
    @(negedge clk);
    chk("flush if_gnt", if_gnt_o, 1);
    cyc();
    if_req_i = 0; mem_gnt_i = 1;
    cyc();
    mem_gnt_i = 0; if_flush_i = 1;
    @(negedge clk);
    chk("flush busy", busy_o, 1);
    cyc();
    if_flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    cyc();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk("flush if_rvalid", if_rvalid_o, 0);
    chk("flush if_rdata held", if_rdata_o, exp_if_rd);
    chk("flush busy done", busy_o, 0);
    v = '{1, 32'h404, 0, 4'h0, 32'h0, 32'h600DF00D, 0, 0, 0, 4'hF};
    run_txn(v, "after-flush");

    // Reset in the response phase, then a stray response in idle.
    cyc();
    dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h800;
    @(negedge clk);
    chk("rstmid dm_gnt", dm_gnt_o, 1);
    cyc();
    dm_req_i = 0; mem_gnt_i = 1;
    cyc();
    mem_gnt_i = 0;
    @(negedge clk);
    chk("rstmid busy", busy_o, 1);
    cyc();
    rst = 1;
    @(negedge clk);
    chk_reset("rstmid");
    cyc();
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray busy", busy_o, 0);
    cyc();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk("stray rvalid", {if_rvalid_o, dm_rvalid_o}, 0);
    chk("stray dm_rdata", dm_rdata_o, 0);
    exp_if_rd = '0;
    exp_dm_rd = '0;
    v = '{0, 32'h804, 0, 4'hF, 32'h0, 32'h13579BDF, 1, 1, 0, 4'hF};
    run_txn(v, "after-reset");

    // Randomized traffic against the reference model.
    cyc();
    clear_inputs();
    rst = 1;
    cyc();
    rst = 0;
    m_act = 0; m_acc = 0; m_own_if = 0; m_drop = 0; m_starve = 0;
    e_if_rv = 0; e_dm_rv = 0; clr_if = 0; clr_dm = 0;
    exp_if_rd = '0; exp_dm_rd = '0;
    m_addr = '0; m_we = 0; m_be = '0; m_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (clr_if) if_req_i = 0;
      if (clr_dm) dm_req_i = 0;
      clr_if = 0; clr_dm = 0;
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (!dm_req_i && $urandom_range(0, 1) == 0) begin
        dm_req_i = 1; dm_we_i = 1'($urandom); dm_be_i = 4'($urandom);
        dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      if_flush_i   = ($urandom_range(0, 7) == 0);
      mem_gnt_i    = (m_act && !m_acc) ? ($urandom_range(0, 1) == 0)
                                       : (!m_act && $urandom_range(0, 7) == 0);
      mem_rvalid_i = m_acc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata_i  = $urandom;
      @(negedge clk);
      g_if = 0; g_dm = 0;
      if (!m_act) begin
        f_ok = if_req_i && !if_flush_i;
        if (dm_req_i && !(f_ok && m_starve == SL)) g_dm = 1;
        else if (f_ok) g_if = 1;
      end
      chk("rnd if_gnt", if_gnt_o, g_if);
      chk("rnd dm_gnt", dm_gnt_o, g_dm);
      chk("rnd mem_req", mem_req_o, m_act && !m_acc);
      chk("rnd busy", busy_o, m_act);
      chk("rnd if_rvalid", if_rvalid_o, e_if_rv);
      chk("rnd dm_rvalid", dm_rvalid_o, e_dm_rv);
      chk("rnd if_rdata", if_rdata_o, exp_if_rd);
      chk("rnd dm_rdata", dm_rdata_o, exp_dm_rd);
      if (m_act && !m_acc) begin
        chk("rnd mem_addr", mem_addr_o, m_addr);
        chk("rnd mem_we", mem_we_o, m_we);
        chk("rnd mem_be", mem_be_o, m_be);
        if (!m_own_if) chk("rnd mem_wdata", mem_wdata_o, m_wdata);
      end
      // Advance the model across the coming clock edge.
      e_if_rv = 0; e_dm_rv = 0;
      if (!m_act) begin
        if (g_if || g_dm) begin
          m_act = 1; m_acc = 0; m_drop = 0; m_own_if = g_if;
          m_addr  = g_if ? if_addr_i : dm_addr_i;
          m_we    = g_if ? 1'b0 : dm_we_i;
          m_be    = g_if ? 4'hF : dm_be_i;
          m_wdata = dm_wdata_i;
        end
        if (g_if || !if_req_i) m_starve = 0;
        else if (g_dm && m_starve < SL) m_starve++;
        clr_if = g_if; clr_dm = g_dm;
      end else if (!m_acc) begin
        if (if_flush_i && m_own_if) m_drop = 1;
        if (mem_gnt_i) m_acc = 1;
      end else if (mem_rvalid_i) begin
        m_act = 0;
        if (!m_own_if) begin
          e_dm_rv = 1; exp_dm_rd = mem_rdata_i;
        end else if (!(m_drop || if_flush_i)) begin
          e_if_rv = 1; exp_if_rd = mem_rdata_i;
        end
      end else if (if_flush_i && m_own_if) begin
        m_drop = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
